// File: rtl/fpcvt_pkg.sv
// Shared types and defaults for the sequential linear-to-float converter.
package fpcvt_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam bit RND_TRUNC   = 1'b0;
  localparam bit RND_HALF_UP = 1'b1;

  localparam int DEF_DW = 12;
  localparam int DEF_EW = 3;
  localparam int DEF_FW = 4;

endpackage

// File: rtl/fpcvt_round.sv
// Rounding, carry-renormalisation and saturation of a normalised significand.
module fpcvt_round
  import fpcvt_pkg::*;
#(
  parameter int EW = DEF_EW,
  parameter int FW = DEF_FW,
  parameter int EC = 4
) (
  input  logic [FW-1:0] mag_lo,
  input  logic          g,
  input  logic [EC-1:0] e,
  input  logic          rnd,
  output logic [EW-1:0] e_out,
  output logic [FW-1:0] f_out,
  output logic          sat
);

  localparam int EMAX = (1 << EW) - 1;

  logic [FW:0]   sum;
  logic [EC-1:0] e_adj;
  logic [FW-1:0] f_adj;

  always_comb begin
    sum   = {1'b0, mag_lo} + {{FW{1'b0}}, (rnd & g)};
    e_adj = e;
    f_adj = sum[FW-1:0];
    e_out = '0;
    f_out = '0;
    sat   = 1'b0;
    // A carry out of the significand renormalises to 100..0 one exponent up.
    if (sum[FW]) begin
      e_adj = e + EC'(1);
      f_adj = {1'b1, {(FW-1){1'b0}}};
    end
    if (int'(e_adj) > EMAX) begin
      sat   = 1'b1;
      e_out = '1;
      f_out = '1;
    end else begin
      e_out = EW'(e_adj);
      f_out = f_adj;
    end
  end

endmodule

// File: rtl/fpcvt_seq.sv
// Handshaked multi-cycle converter: two's-complement sample to sign/exponent/significand,
// normalising by one right-shift per clock.
module fpcvt_seq
  import fpcvt_pkg::*;
#(
  parameter int DW  = DEF_DW,
  parameter int EW  = DEF_EW,
  parameter int FW  = DEF_FW,
  parameter bit RND = RND_HALF_UP
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] D,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          S,
  output logic [EW-1:0] E,
  output logic [FW-1:0] F,
  output logic          SAT,
  output logic [1:0]    dbg_state
);

  localparam int EC = $clog2(DW - FW + 2);
  localparam logic [DW-1:0] ONE = DW'(1);

  state_e        state;
  logic [DW-1:0] mag;
  logic [EC-1:0] e_cnt;
  logic          g;
  logic          s_q;
  logic [EW-1:0] e_rnd;
  logic [FW-1:0] f_rnd;
  logic          sat_rnd;
  logic          need_shift;

  // Valid/ready: a transfer happens on any rising edge where valid and ready are both
  // high; in_ready is high only in IDLE, out_valid only in DONE, and results hold
  // until the consumer takes them.
  assign in_ready   = (state == IDLE);
  assign out_valid  = (state == DONE);
  assign dbg_state  = state;
  assign need_shift = |mag[DW-1:FW];

  fpcvt_round #(
    .EW(EW),
    .FW(FW),
    .EC(EC)
  ) u_round (
    .mag_lo(mag[FW-1:0]),
    .g     (g),
    .e     (e_cnt),
    .rnd   (RND),
    .e_out (e_rnd),
    .f_out (f_rnd),
    .sat   (sat_rnd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      mag   <= '0;
      e_cnt <= '0;
      g     <= 1'b0;
      s_q   <= 1'b0;
      S     <= 1'b0;
      E     <= '0;
      F     <= '0;
      SAT   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            s_q   <= D[DW-1];
            // The most negative input maps to 2^(DW-1), which still fits unsigned.
            mag   <= D[DW-1] ? (~D + ONE) : D;
            e_cnt <= '0;
            g     <= 1'b0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (need_shift) begin
            g     <= mag[0];
            mag   <= mag >> 1;
            e_cnt <= e_cnt + EC'(1);
          end else begin
            state <= ROUND;
          end
        end
        ROUND: begin
          S     <= s_q;
          E     <= e_rnd;
          F     <= f_rnd;
          SAT   <= sat_rnd;
          state <= DONE;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpcvt_seq.sv
// Bench for fpcvt_seq: two instances (round-half-up and truncate) driven in lockstep
// and checked against an arithmetic model of the conversion.
module tb_fpcvt_seq;
  import fpcvt_pkg::*;

  localparam int DW = DEF_DW;
  localparam int EW = DEF_EW;
  localparam int FW = DEF_FW;
  localparam int RW = 1 + EW + FW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b1;
  logic [DW-1:0] d = '0;

  logic          ir1, ov1, s1, sat1;
  logic [EW-1:0] e1;
  logic [FW-1:0] f1;
  logic [1:0]    st1;
  logic          ir0, ov0, s0, sat0;
  logic [EW-1:0] e0;
  logic [FW-1:0] f0;
  logic [1:0]    st0;

  // Entry: {sign, {sat,E,F} for half-up, {sat,E,F} for truncate}
  logic [2*RW:0] exp_q[$];
  logic [2*RW:0] cur;
  int            n_checks = 0;
  int            n_pass = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  fpcvt_seq #(.DW(DW), .EW(EW), .FW(FW), .RND(RND_HALF_UP)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir1), .D(d),
    .out_valid(ov1), .out_ready(out_ready), .S(s1), .E(e1), .F(f1), .SAT(sat1),
    .dbg_state(st1)
  );

  fpcvt_seq #(.DW(DW), .EW(EW), .FW(FW), .RND(RND_TRUNC)) dut_trunc (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir0), .D(d),
    .out_valid(ov0), .out_ready(out_ready), .S(s0), .E(e0), .F(f0), .SAT(sat0),
    .dbg_state(st0)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  function automatic int mag_of(input logic [DW-1:0] x);
    return x[DW-1] ? (1 << DW) - int'(x) : int'(x);
  endfunction

  function automatic int k_of(input logic [DW-1:0] x);
    int m = mag_of(x);
    int k = 0;
    while ((m >> k) >= (1 << FW)) k++;
    return k;
  endfunction

  function automatic logic [RW-1:0] model(input logic [DW-1:0] x, input bit rnd);
    int m, k, g, f, e;
    m = mag_of(x);
    k = k_of(x);
    g = (k > 0) ? ((m >> (k - 1)) & 1) : 0;
    f = (m >> k) + (rnd ? g : 0);
    e = k;
    if (f == (1 << FW)) begin
      f = 1 << (FW - 1);
      e = k + 1;
    end
    if (e > (1 << EW) - 1) return {1'b1, {EW{1'b1}}, {FW{1'b1}}};
    return {1'b0, EW'(e), FW'(f)};
  endfunction

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    if (rst_n && (ov1 || ov0)) begin
      if (exp_q.size() == 0) begin
        chk("spurious_out_valid", 1, 0);
      end else begin
        cur = exp_q[0];
        chk("ov_half_up", int'(ov1), 1);
        chk("ov_trunc", int'(ov0), 1);
        chk("sign_half_up", int'(s1), int'(cur[2*RW]));
        chk("sign_trunc", int'(s0), int'(cur[2*RW]));
        chk("res_half_up", int'({sat1, e1, f1}), int'(cur[2*RW-1:RW]));
        chk("res_trunc", int'({sat0, e0, f0}), int'(cur[RW-1:0]));
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [DW-1:0] din, input int hold);
    int k, cyc;
    k = k_of(din);
    exp_q.push_back({din[DW-1], model(din, 1'b1), model(din, 1'b0)});
    out_ready = (hold == 0);
    cyc = 0;
    while (!ir1 && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("in_ready_wait", int'(ir1), 1);
    d = din;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    d = DW'($urandom);
    cyc = 0;
    while (!ov1 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("latency", cyc, k + 2);
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        d = DW'($urandom);
        in_valid = 1'b1;
        @(posedge clk); #1;
        chk("busy_in_ready", int'(ir1), 0);
        chk("held_out_valid", int'(ov1), 1);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    chk("in_ready_after_hs", int'(ir1), 1);
    chk("out_valid_drop", int'(ov1), 0);
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_in_ready"}, int'(ir1), 1);
    chk({tag, "_out_valid"}, int'(ov1 | ov0), 0);
    chk({tag, "_outs_half_up"}, int'({s1, sat1, e1, f1}), 0);
    chk({tag, "_outs_trunc"}, int'({s0, sat0, e0, f0}), 0);
    chk({tag, "_state"}, int'(st1), int'(IDLE));
  endtask

  task automatic reset_mid_shift(input logic [DW-1:0] din);
    out_ready = 1'b1;
    d = din;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("pre_reset_state", int'(st1), int'(SHIFT));
    rst_n = 1'b0;
    #1;
    check_cleared("mid_reset");
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      chk("no_out_valid_after_reset", int'(ov1 | ov0), 0);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_cleared("reset");

    // Hand-worked values pinning the model
    chk("pin_1a", int'(model(12'h01A, 1'b1)), int'({1'b0, 3'd1, 4'b1101}));
    chk("pin_1f_up", int'(model(12'h01F, 1'b1)), int'({1'b0, 3'd2, 4'b1000}));
    chk("pin_1f_trunc", int'(model(12'h01F, 1'b0)), int'({1'b0, 3'd1, 4'b1111}));
    chk("pin_800", int'(model(12'h800, 1'b1)), int'({1'b1, 3'b111, 4'b1111}));
    chk("pin_f00", int'(model(12'hF00, 1'b1)), int'({1'b0, 3'b101, 4'b1000}));
    chk("pin_k_800", k_of(12'h800), 8);
    chk("pin_k_0", k_of(12'h000), 0);

    rst_n = 1'b1;
    @(posedge clk); #1;

    send(12'h000, 0);
    send(12'h01A, 0);
    send(12'h01F, 0);
    send(12'h800, 0);
    send(12'hF00, 0);
    send(12'h7FF, 0);
    send(12'hFFF, 0);
    send(12'h00F, 0);
    send(12'h123, 5);

    reset_mid_shift(12'h800);
    send(12'h01F, 0);

    for (int i = 0; i < 60; i++) begin
      send(DW'($urandom_range(0, (1 << DW) - 1)),
           ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
